// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, runs the imem req/ack handshake and
// presents registered {instruction, pc+4, valid} to the IF/ID register.
module if_fetch_stage #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        clk_IF,
    input  logic        rstn_IF,
    input  logic        stall_IF,
    input  logic        branch_IF,
    input  logic [7:0]  target_IF,
    output logic        imem_req_IF,
    output logic [7:0]  imem_addr_IF,
    input  logic        imem_ack_IF,
    input  logic [31:0] imem_rdata_IF,
    output logic [31:0] instruction_IF,
    output logic [7:0]  nextInst_IF,
    output logic        valid_IF,
    output logic [7:0]  pc_IF
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH     = 2'd1,
        WAIT_SLOT = 2'd2,
        KILL      = 2'd3
    } state_t;

    function automatic logic [7:0] pc_plus4(input logic [7:0] pc);
        return pc + 8'd4;
    endfunction

    state_t      state_r, state_s;
    logic [7:0]  pc_r, pc_s;
    logic [31:0] inst_r, inst_s;
    logic [7:0]  next_r, next_s;
    logic        valid_r, valid_s;
    logic        req_r, req_s;
    logic        skid_valid_r, skid_valid_s;
    logic [31:0] skid_inst_r, skid_inst_s;
    logic [7:0]  skid_next_r, skid_next_s;
    logic        blocked_s;

    assign blocked_s = valid_r & stall_IF;

    // Next-state, PC, output-slot and skid selection
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        inst_s       = inst_r;
        next_s       = next_r;
        valid_s      = valid_r;
        skid_valid_s = skid_valid_r;
        skid_inst_s  = skid_inst_r;
        skid_next_s  = skid_next_r;

        if (branch_IF) begin
            // Redirect wins over stall; an unacked request must still be drained
            pc_s         = {target_IF[7:2], 2'b00};
            inst_s       = NOP_WORD;
            valid_s      = 1'b0;
            skid_valid_s = 1'b0;
            case (state_r)
                FETCH:     state_s = imem_ack_IF ? FETCH : KILL;
                KILL:      state_s = KILL;
                IDLE:      state_s = FETCH;
                WAIT_SLOT: state_s = FETCH;
                default:   state_s = IDLE;
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = FETCH;
                    if (!blocked_s) begin
                        inst_s  = NOP_WORD;
                        valid_s = 1'b0;
                    end else begin
                        inst_s  = inst_r;
                        valid_s = valid_r;
                    end
                end
                FETCH: begin
                    if (imem_ack_IF) begin
                        pc_s = pc_plus4(pc_r);
                        if (!blocked_s) begin
                            inst_s  = imem_rdata_IF;
                            next_s  = pc_plus4(pc_r);
                            valid_s = 1'b1;
                        end else begin
                            skid_valid_s = 1'b1;
                            skid_inst_s  = imem_rdata_IF;
                            skid_next_s  = pc_plus4(pc_r);
                            state_s      = WAIT_SLOT;
                        end
                    end else if (!blocked_s) begin
                        inst_s  = NOP_WORD;
                        valid_s = 1'b0;
                    end else begin
                        inst_s  = inst_r;
                        valid_s = valid_r;
                    end
                end
                WAIT_SLOT: begin
                    if (!stall_IF) begin
                        inst_s       = skid_inst_r;
                        next_s       = skid_next_r;
                        valid_s      = skid_valid_r;
                        skid_valid_s = 1'b0;
                        state_s      = FETCH;
                    end else begin
                        state_s = WAIT_SLOT;
                    end
                end
                KILL: begin
                    if (imem_ack_IF) begin
                        state_s = FETCH;
                    end else begin
                        state_s = KILL;
                    end
                    if (!blocked_s) begin
                        inst_s  = NOP_WORD;
                        valid_s = 1'b0;
                    end else begin
                        inst_s  = inst_r;
                        valid_s = valid_r;
                    end
                end
                default: state_s = IDLE;
            endcase
        end

        req_s = (state_s == FETCH) || (state_s == KILL);
    end

    // State, PC, output slot and skid registers
    always_ff @(posedge clk_IF or negedge rstn_IF) begin
        if (!rstn_IF) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            inst_r       <= NOP_WORD;
            next_r       <= 8'h00;
            valid_r      <= 1'b0;
            req_r        <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_inst_r  <= NOP_WORD;
            skid_next_r  <= 8'h00;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            inst_r       <= inst_s;
            next_r       <= next_s;
            valid_r      <= valid_s;
            req_r        <= req_s;
            skid_valid_r <= skid_valid_s;
            skid_inst_r  <= skid_inst_s;
            skid_next_r  <= skid_next_s;
        end
    end

    assign imem_req_IF    = req_r;
    assign imem_addr_IF   = pc_r;
    assign pc_IF          = pc_r;
    assign instruction_IF = inst_r;
    assign nextInst_IF    = next_r;
    assign valid_IF       = valid_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed stimulus pushes expected words,
// a negedge monitor pops one per consumed (valid, unstalled) output slot.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rstn, stall, branch, ack_en, force_bad;
    logic [7:0]  target;
    logic        req, ack, valid;
    logic [7:0]  addr, next, pc;
    logic [31:0] rdata, inst;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        logic [31:0] idx;
        idx = {26'd0, a[7:2]};
        return idx * 32'h11111111;
    endfunction

    assign ack   = ack_en & req;
    assign rdata = force_bad ? 32'hDEADBEEF : mem_word(addr);

    if_fetch_stage #(.RESET_PC(8'h00), .NOP_WORD(32'h00000000)) dut (
        .clk_IF(clk), .rstn_IF(rstn), .stall_IF(stall), .branch_IF(branch),
        .target_IF(target), .imem_req_IF(req), .imem_addr_IF(addr),
        .imem_ack_IF(ack), .imem_rdata_IF(rdata), .instruction_IF(inst),
        .nextInst_IF(next), .valid_IF(valid), .pc_IF(pc)
    );

    typedef struct {
        logic [31:0] word;
        logic [7:0]  nxt;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic [7:0] n);
        exp_t e;
        e.word = w;
        e.nxt  = n;
        q.push_back(e);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: a word is consumed on the coming edge when valid and not stalled
    always @(negedge clk) begin
        if (rstn && valid && !stall) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%h required=none", inst);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_inst", inst, e.word);
                chk("sb_next", {24'd0, next}, {24'd0, e.nxt});
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; stall = 1'b0; branch = 1'b0; target = 8'h00;
        ack_en = 1'b1; force_bad = 1'b0;
        #12;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_inst", inst, 32'h00000000);
        chk("rst_next", {24'd0, next}, 32'h00);
        chk("rst_pc", {24'd0, pc}, 32'h00);
        chk("rst_req", {31'd0, req}, 32'd0);

        // Streaming fetch, then a 3-cycle stall exercising the skid
        push(32'h00000000, 8'h04);
        push(32'h11111111, 8'h08);
        push(32'h22222222, 8'h0C);
        push(32'h33333333, 8'h10);
        push(32'h44444444, 8'h14);
        @(negedge clk);
        rstn = 1'b1;
        step;
        chk("first_valid_low", {31'd0, valid}, 32'd0);
        chk("first_req", {31'd0, req}, 32'd1);
        step;
        chk("first_valid_high", {31'd0, valid}, 32'd1);
        chk("first_next", {24'd0, next}, 32'h04);
        step; step;
        chk("stream_pc", {24'd0, pc}, 32'h0C);
        stall = 1'b1;
        step;
        chk("stall_req_low", {31'd0, req}, 32'd0);
        chk("stall_inst_hold", inst, 32'h22222222);
        step; step;
        chk("stall_inst_frozen", inst, 32'h22222222);
        chk("stall_next_frozen", {24'd0, next}, 32'h0C);
        stall = 1'b0;
        step;
        chk("skid_out", inst, 32'h33333333);
        chk("skid_req_back", {31'd0, req}, 32'd1);
        step;

        // Redirect while a request is unacked: orphan drained in KILL
        ack_en = 1'b0; branch = 1'b1; target = 8'h41;
        step;
        branch = 1'b0; target = 8'h00;
        chk("kill_valid", {31'd0, valid}, 32'd0);
        chk("kill_pc", {24'd0, pc}, 32'h40);
        chk("kill_req", {31'd0, req}, 32'd1);
        step;
        ack_en = 1'b1; force_bad = 1'b1;
        step;
        force_bad = 1'b0;
        chk("kill_drop_inst", inst, 32'h00000000);
        chk("kill_drop_valid", {31'd0, valid}, 32'd0);
        chk("kill_addr", {24'd0, addr}, 32'h40);
        push(32'h11111110, 8'h44);
        step;
        chk("after_kill_inst", inst, 32'h11111110);

        // Redirect coincident with ack, then redirect while stalled
        branch = 1'b1; target = 8'h80;
        step;
        branch = 1'b0;
        chk("br_ack_valid", {31'd0, valid}, 32'd0);
        chk("br_ack_addr", {24'd0, addr}, 32'h80);
        step;
        chk("br_ack_word", inst, 32'h22222220);
        stall = 1'b1; branch = 1'b1; target = 8'hC3;
        step;
        branch = 1'b0; stall = 1'b0;
        chk("br_stall_valid", {31'd0, valid}, 32'd0);
        chk("br_stall_inst", inst, 32'h00000000);
        chk("br_stall_pc", {24'd0, pc}, 32'hC0);

        // PC wrap at 0xFC
        push(32'h33333330, 8'hC4);
        push(32'h2222221E, 8'hFC);
        push(32'h3333332F, 8'h00);
        step;
        branch = 1'b1; target = 8'hF8;
        step;
        branch = 1'b0;
        step; step;
        chk("wrap_next", {24'd0, next}, 32'h00);
        chk("wrap_pc", {24'd0, pc}, 32'h00);
        chk("wrap_inst", inst, 32'h3333332F);
        step;
        chk("wrap_cont_pc", {24'd0, pc}, 32'h04);
        chk("wrap_cont_valid", {31'd0, valid}, 32'd1);

        // Asynchronous reset between edges with a request outstanding
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_inst", inst, 32'h00000000);
        chk("arst_next", {24'd0, next}, 32'h00);
        chk("arst_pc", {24'd0, pc}, 32'h00);
        chk("arst_req", {31'd0, req}, 32'd0);
        @(negedge clk);
        #3;
        push(32'h00000000, 8'h04);
        push(32'h11111111, 8'h08);
        rstn = 1'b1;
        step;
        chk("restart_valid_low", {31'd0, valid}, 32'd0);
        chk("restart_addr", {24'd0, addr}, 32'h00);
        step;
        chk("restart_valid_high", {31'd0, valid}, 32'd1);
        chk("restart_next", {24'd0, next}, 32'h04);
        step;
        ack_en = 1'b0;
        step; step; step;
        chk("sb_drain", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
